// File: rtl/p1n2ser_pkg.sv
// p1n2ser_pkg: shared types and constants for the P1N2SERX1 self-test sequencer.
// Holds the FSM state encoding, the eight-vector {A,B,C} ROM, the expected Z
// per vector and the check masks (1 = vector is compared).
package p1n2ser_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_APPLY  = 3'd1,
        ST_SETTLE = 3'd2,
        ST_SAMPLE = 3'd3,
        ST_DONE   = 3'd4
    } state_t;

    // {A,B,C} per vector index; element [0] is idx0.
    localparam logic [7:0][2:0] VEC_ROM = {
        3'b011,  // idx7 contention
        3'b010,  // idx6
        3'b110,  // idx5 float
        3'b001,  // idx4
        3'b101,  // idx3 float
        3'b111,  // idx2
        3'b100,  // idx1 float
        3'b000   // idx0
    };

    // Expected Z per index; float entries hold the value of the preceding driven vector.
    localparam logic [7:0] EXP_Z = 8'b0111_0011;

    // Driven vectors only (idx0, idx2, idx4, idx6).
    localparam logic [7:0] MASK_BASE  = 8'b0101_0101;
    // Driven vectors plus the float retention vectors; idx7 never checked.
    localparam logic [7:0] MASK_FLOAT = 8'b0111_1111;

endpackage

// File: rtl/p1n2ser_stim_chk_if.sv
// p1n2ser_stim_chk_if: control, cell-side and result signals of the sequencer.
// master = host/cell side (drives START and ZIN), slave = the sequencer.
interface p1n2ser_stim_chk_if #(
    parameter int CNT_W = 8
);
    logic             START;
    logic             ZIN;
    logic             A;
    logic             B;
    logic             C;
    logic             BUSY;
    logic             DONE;
    logic             PASS;
    logic [CNT_W-1:0] FAIL_CNT;
    logic [2:0]       FIRST_FAIL;

    modport master (
        output START, ZIN,
        input  A, B, C, BUSY, DONE, PASS, FAIL_CNT, FIRST_FAIL
    );

    modport slave (
        input  START, ZIN,
        output A, B, C, BUSY, DONE, PASS, FAIL_CNT, FIRST_FAIL
    );
endinterface

// File: rtl/p1n2ser_sync2.sv
// p1n2ser_sync2: two-flop synchronizer for the asynchronous Z of the cell under test.
module p1n2ser_sync2 (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);
    logic meta_q;
    logic sync_q;

    // Two-stage capture, both stages cleared by reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= d;
            sync_q <= meta_q;
        end
    end

    assign q = sync_q;
endmodule

// File: rtl/p1n2ser_stim_chk.sv
// p1n2ser_stim_chk: self-test sequencer for the P1N2SERX1 cell.
// Walks eight {A,B,C} vectors, samples synchronized Z after SETTLE_CYC cycles and
// counts mismatches. Define P1N2SER_FLOAT_CHK_EN to also check the float vectors.
// All outputs are registered off the state, so DONE/BUSY/A/B/C settle one cycle
// after the FSM enters DONE.
module p1n2ser_stim_chk
    import p1n2ser_pkg::*;
#(
    parameter int SETTLE_CYC = 4,
    parameter int LOOPS      = 1,
    parameter int CNT_W      = 8
) (
    input logic               CK,
    input logic               R,
    p1n2ser_stim_chk_if.slave io
);
    localparam int SW = $clog2(SETTLE_CYC);
    localparam int LW = (LOOPS > 1) ? $clog2(LOOPS) : 1;

`ifdef P1N2SER_FLOAT_CHK_EN
    localparam logic [7:0] CHK_MASK = MASK_FLOAT;
`else
    localparam logic [7:0] CHK_MASK = MASK_BASE;
`endif

    state_t           state_q, state_d;
    logic [2:0]       idx_q, idx_d;
    logic [LW-1:0]    loop_q, loop_d;
    logic [SW-1:0]    set_q, set_d;
    logic [2:0]       abc_q, abc_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [CNT_W-1:0] fail_q, fail_d;
    logic [2:0]       first_q, first_d;
    logic             zs;
    logic             mismatch;

    p1n2ser_sync2 u_sync (
        .clk (CK),
        .rst (R),
        .d   (io.ZIN),
        .q   (zs)
    );

    // X/Z on the synchronized Z counts as a mismatch.
    assign mismatch = (zs !== EXP_Z[idx_q]);

    // Next-state and result update for the vector walk.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        loop_d  = loop_q;
        set_d   = set_q;
        abc_d   = abc_q;
        busy_d  = busy_q;
        done_d  = done_q;
        fail_d  = fail_q;
        first_d = first_q;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (state_q == ST_DONE) begin
                    abc_d  = 3'b000;
                    busy_d = 1'b0;
                    done_d = 1'b1;
                end
                if (io.START) begin
                    state_d = ST_APPLY;
                    idx_d   = 3'd0;
                    loop_d  = '0;
                    fail_d  = '0;
                    first_d = 3'd0;
                    done_d  = 1'b0;
                end
            end
            ST_APPLY: begin
                abc_d   = VEC_ROM[idx_q];
                busy_d  = 1'b1;
                set_d   = '0;
                state_d = ST_SETTLE;
            end
            ST_SETTLE: begin
                if (set_q == SW'(SETTLE_CYC - 1)) state_d = ST_SAMPLE;
                else                              set_d   = set_q + SW'(1);
            end
            ST_SAMPLE: begin
                if (CHK_MASK[idx_q] && mismatch) begin
                    if (fail_q == '0) first_d = idx_q;
                    if (fail_q != '1) fail_d  = fail_q + CNT_W'(1);
                end
                if (idx_q == 3'd7 && loop_q == LW'(LOOPS - 1)) begin
                    state_d = ST_DONE;
                end else begin
                    idx_d   = idx_q + 3'd1;
                    if (idx_q == 3'd7) loop_d = loop_q + LW'(1);
                    state_d = ST_APPLY;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and output registers; reset drops everything back to the idle vector.
    always_ff @(posedge CK or posedge R) begin
        if (R) begin
            state_q <= ST_IDLE;
            idx_q   <= 3'd0;
            loop_q  <= '0;
            set_q   <= '0;
            abc_q   <= 3'b000;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            fail_q  <= '0;
            first_q <= 3'd0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            loop_q  <= loop_d;
            set_q   <= set_d;
            abc_q   <= abc_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            fail_q  <= fail_d;
            first_q <= first_d;
        end
    end

    assign io.A          = abc_q[2];
    assign io.B          = abc_q[1];
    assign io.C          = abc_q[0];
    assign io.BUSY       = busy_q;
    assign io.DONE       = done_q;
    assign io.PASS       = done_q && (fail_q == '0);
    assign io.FAIL_CNT   = fail_q;
    assign io.FIRST_FAIL = first_q;
endmodule
